// File: rtl/io_panel_pkg.sv
// Shared definitions for the front-panel controller: segment encoding and
// bit positions of the active-low seg bus.
package io_panel_pkg;

    localparam int SEG_CATH_W = 8;
    localparam int SEG_DP_BIT = 7;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low cathode pattern, bits [6:0] = g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] pat;
        case (hex)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    function automatic logic [7:0] digit_cathodes(input logic [3:0] hex,
                                                   input logic       dp_on,
                                                   input logic       dark);
        return dark ? SEG_BLANK : {~dp_on, hex_to_seg(hex)};
    endfunction

endpackage

// File: rtl/io_panel_btn_debounce.sv
// One push button: 2-FF synchroniser, stability-count debounce, press edge
// pulse and optional auto-repeat while held.
module btn_debounce #(
    parameter int DB_CYCLES  = 256,
    parameter int REPEAT_DLY = 0,
    parameter int REPEAT_PER = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'((REPEAT_DLY > 0) ? REPEAT_DLY - 1 : 0);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER - 1);
    localparam logic             RPT_EN   = (REPEAT_DLY > 0) ? 1'b1 : 1'b0;

    logic             sync_p0;
    logic             sync_p1;
    logic [DB_W-1:0]  db_cnt;
    logic             level_q;
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_on;
    logic             rpt_first;
    logic             flip;
    logic             level_nxt;

    assign flip      = (sync_p1 != level) && (db_cnt == DB_LAST);
    assign level_nxt = level ^ flip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            db_cnt    <= '0;
            level     <= 1'b0;
            level_q   <= 1'b0;
            press     <= 1'b0;
            rpt_cnt   <= '0;
            rpt_on    <= 1'b0;
            rpt_first <= 1'b0;
        end else begin
            // synchroniser stage
            sync_p0 <= btn;
            sync_p1 <= sync_p0;

            // stability counter stage
            if ((sync_p1 == level) || flip) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            level   <= level_nxt;
            level_q <= level;

            // Looking at level_nxt kills any repeat pulse in the release cycle.
            press <= 1'b0;
            if (!level_nxt) begin
                rpt_on  <= 1'b0;
                rpt_cnt <= '0;
            end else if (level && !level_q) begin
                press     <= 1'b1;
                rpt_on    <= RPT_EN;
                rpt_first <= 1'b1;
                rpt_cnt   <= '0;
            end else if (rpt_on) begin
                if (rpt_cnt == (rpt_first ? DLY_LAST : PER_LAST)) begin
                    press     <= 1'b1;
                    rpt_first <= 1'b0;
                    rpt_cnt   <= '0;
                end else begin
                    rpt_cnt <= rpt_cnt + RPT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/io_panel.sv
// Front-panel controller: per-button debounce/edge/repeat and a multiplexed
// active-low 7-segment scanner with a dark guard cycle at each slot start.
module io_panel
    import io_panel_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int BTNS       = 5,
    parameter int SCAN_DIV   = 1024,
    parameter int DB_CYCLES  = 256,
    parameter int REPEAT_DLY = 0,
    parameter int REPEAT_PER = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BTNS-1:0]       btn,
    input  logic [4*DIGITS-1:0]   val,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [7+DIGITS:0]     seg,
    output logic [BTNS-1:0]       btn_level,
    output logic [BTNS-1:0]       btn_press
);

    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

    for (genvar i = 0; i < BTNS; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .REPEAT_DLY(REPEAT_DLY),
            .REPEAT_PER(REPEAT_PER)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn[i]),
            .level(btn_level[i]),
            .press(btn_press[i])
        );
    end

    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic [SLOT_W-1:0]     slot;
    logic [SEG_CATH_W-1:0] cath_cur;
    logic [SEG_CATH_W-1:0] cath_nxt;
    logic [DIGITS-1:0]     an_cur;

    assign idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);

    always_comb begin
        cath_cur = SEG_BLANK;
        cath_nxt = SEG_BLANK;
        an_cur   = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (IDX_W'(k) == idx) begin
                cath_cur  = digit_cathodes(val[4*k +: 4], dp[k], blank[k]);
                an_cur[k] = 1'b0;
            end
            if (IDX_W'(k) == idx_nxt) begin
                cath_nxt = digit_cathodes(val[4*k +: 4], dp[k], blank[k]);
            end
        end
    end

    // Guard cycle previews the next digit with anodes off; the edge leaving
    // the guard cycle resamples the inputs and lights the anode, then seg
    // holds for the rest of the slot so mid-slot input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg  <= '1;
            idx  <= '0;
            slot <= '0;
        end else if (slot == SLOT_LAST) begin
            slot <= '0;
            idx  <= idx_nxt;
            seg  <= {{DIGITS{1'b1}}, cath_nxt};
        end else begin
            slot <= slot + SLOT_W'(1);
            if (slot == '0) begin
                seg <= {an_cur, cath_cur};
            end
        end
    end

endmodule

// File: tb/tb_io_panel.sv
// Directed bench for io_panel: reset, scan order, blanking, mid-slot changes,
// debounce, simultaneous presses, auto-repeat and reset during a press.
module tb_io_panel;

    localparam int DIGITS     = 4;
    localparam int BTNS       = 5;
    localparam int SCAN_DIV   = 8;
    localparam int DB_CYCLES  = 16;
    localparam int REPEAT_DLY = 50;
    localparam int REPEAT_PER = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  btn;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [11:0] seg;
    logic [4:0]  btn_level;
    logic [4:0]  btn_press;

    int n_vec = 0;
    int n_bad = 0;
    int dig = 0;
    int cyc = 0;

    logic [11:0] exp_slot [4] = '{12'hEC0, 12'hDF9, 12'hB08, 12'h7B0};

    always #5 clk = ~clk;

    io_panel #(
        .DIGITS    (DIGITS),
        .BTNS      (BTNS),
        .SCAN_DIV  (SCAN_DIV),
        .DB_CYCLES (DB_CYCLES),
        .REPEAT_DLY(REPEAT_DLY),
        .REPEAT_PER(REPEAT_PER)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .val      (val),
        .dp       (dp),
        .blank    (blank),
        .seg      (seg),
        .btn_level(btn_level),
        .btn_press(btn_press)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = (cyc + 1) % SCAN_DIV;
        if (cyc == 0) dig = (dig + 1) % DIGITS;
    endtask

    task automatic goto(input int d, input int c);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(dig == d && cyc == c) && n < 64);
        check("goto_slot", {31'b0, (dig == d && cyc == c)}, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int first;
        int n;

        btn   = 5'($urandom);
        val   = 16'($urandom);
        dp    = 4'($urandom);
        blank = 4'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("reset_seg", seg, 12'hFFF);
        check("reset_level", btn_level, 0);
        check("reset_press", btn_press, 0);

        btn   = '0;
        val   = 16'h3A10;
        dp    = 4'b0100;
        blank = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dig = 0;
        cyc = 0;
        tick();
        check("anode0_cycle1", seg, 12'hEC0);

        // Scan digits 0,1,2,3 and wrap to 0, each slot led by a dark guard cycle.
        for (int s = 0; s < 5; s++) begin
            for (int c = 1; c < SCAN_DIV; c++) begin
                check($sformatf("scan_s%0d_c%0d", s, c), seg, exp_slot[s % 4]);
                tick();
            end
            check($sformatf("guard_s%0d", s), seg[11:8], 4'hF);
            tick();
        end

        // Blanking and mid-slot changes only take effect in the next slot.
        goto(1, 3);
        blank = 4'b0010;
        check("blank_midslot_old", seg, 12'hDF9);
        goto(1, 1);
        check("blank_applied", seg, 12'hDFF);
        blank = 4'b0000;
        goto(1, 5);
        check("unblank_midslot_old", seg, 12'hDFF);
        goto(1, 1);
        check("unblank_applied", seg, 12'hDF9);
        goto(1, 4);
        val = 16'h3A70;
        goto(1, 6);
        check("val_midslot_old", seg, 12'hDF9);
        goto(0, 2);
        check("digit0_unchanged", seg, 12'hEC0);
        goto(1, 1);
        check("val_next_slot", seg, 12'hDF8);

        // Bouncing btn[2], 5-cycle toggles, never long enough to settle.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            btn[2] = ~btn[2];
            repeat (5) begin
                tick();
                if (btn_press[2]) pulses++;
            end
        end
        check("bounce_no_press", pulses, 0);
        check("bounce_level_low", {31'b0, btn_level[2]}, 0);
        btn[2] = 1'b1;
        pulses = 0;
        first = -1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (btn_press[2]) begin
                pulses++;
                if (first < 0) first = t;
            end
            if (t == 17) check("db_level_t17", {31'b0, btn_level[2]}, 0);
            if (t == 18) check("db_level_t18", {31'b0, btn_level[2]}, 1);
        end
        check("db_press_latency", first, 19);
        check("db_press_count", pulses, 1);
        btn[2] = 1'b0;
        repeat (25) tick();
        check("db_release_level", {31'b0, btn_level[2]}, 0);

        // Simultaneous presses on buttons 1 and 3.
        btn[1] = 1'b1;
        btn[3] = 1'b1;
        repeat (19) tick();
        check("simul_press", btn_press, 5'b01010);
        tick();
        check("simul_press_end", btn_press, 5'b00000);
        btn[1] = 1'b0;
        btn[3] = 1'b0;
        repeat (25) tick();
        check("simul_release", btn_level, 5'b00000);

        // Auto-repeat on btn[0]: pulses at offsets 0, 50, 70, ..., 190.
        btn[0] = 1'b1;
        n = 0;
        while (!btn_press[0] && n < 40) begin
            tick();
            n++;
        end
        check("rpt_first_press", {31'b0, btn_press[0]}, 1);
        check("rpt_first_latency", n, 19);
        pulses = 1;
        for (int off = 1; off <= 260; off++) begin
            tick();
            if (off == 191) btn[0] = 1'b0;
            if (btn_press[0]) pulses++;
            if (off >= 50 && off <= 190 && (off - 50) % 20 == 0)
                check($sformatf("rpt_pulse_%0d", off), {31'b0, btn_press[0]}, 1);
        end
        check("rpt_pulse_count", pulses, 9);
        check("rpt_release_level", {31'b0, btn_level[0]}, 0);

        // Reset in the middle of a held press, then a fresh press after reset.
        btn[4] = 1'b1;
        n = 0;
        while (!btn_level[4] && n < 40) begin
            tick();
            n++;
        end
        check("rst_mid_level_high", {31'b0, btn_level[4]}, 1);
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_mid_level", btn_level, 0);
        check("rst_mid_press", btn_press, 0);
        check("rst_mid_seg", seg, 12'hFFF);
        rst_n = 1'b1;
        pulses = 0;
        first = -1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (btn_press[4]) begin
                pulses++;
                if (first < 0) first = t;
            end
            if (t == 1) check("rst_mid_anode0", seg[11:8], 4'hE);
        end
        check("rst_mid_press_latency", first, DB_CYCLES + 3);
        check("rst_mid_press_count", pulses, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
